// File: rtl/chu_pwm_pkg.sv
// ============================================================================
// Module  : chu_pwm_pkg
// Purpose : Shared constants for the chu_pwm_led slot core: the word
//           addresses of the slot registers and the CTRL bit layout.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package chu_pwm_pkg;

    // Slot register word addresses
    localparam logic [4:0] PWM_DVSR      = 5'h00;
    localparam logic [4:0] PWM_CTRL      = 5'h01;
    localparam logic [4:0] PWM_CNT       = 5'h02;
    localparam logic [4:0] PWM_DUTY_BASE = 5'h10;

    // CTRL register bit positions
    localparam int EN_BIT = 0;

    // True when a slot address selects DUTY[idx]
    function automatic logic is_duty_addr(input logic [4:0] a, input int idx);
        return (a == (PWM_DUTY_BASE + 5'(idx)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_tick_gen.sv
// ============================================================================
// Module  : pwm_tick_gen
// Purpose : Shared timebase for the PWM core. A 32-bit prescaler produces a
//           tick every (dvsr+1) clocks; an R-bit period counter advances on
//           each tick and flags the tick that rolls it over (wrap).
// Ports   : clk, reset     - clock, synchronous active-high reset
//           i_en           - run enable; when low both counters are held at 0
//           i_dvsr         - prescaler terminal count
//           i_dvsr_wr      - DVSR is being written this cycle (restart prescale)
//           o_tick         - prescaler terminal count reached
//           o_wrap         - tick on the last count of the period
//           o_d            - current period count
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_tick_gen #(
    parameter int R = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [31:0]  i_dvsr,
    input  logic         i_dvsr_wr,
    output logic         o_tick,
    output logic         o_wrap,
    output logic [R-1:0] o_d
);

    logic [31:0]  r_q;
    logic [R-1:0] r_d;

    assign o_tick = i_en && (r_q == i_dvsr);
    assign o_wrap = o_tick && (r_d == {R{1'b1}});
    assign o_d    = r_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
            r_d <= '0;
        end else if (!i_en) begin
            r_q <= '0;
            r_d <= '0;
        end else begin
            // A new divisor restarts the prescale interval so the first
            // tick after a DVSR write is a full (dvsr+1) clocks away.
            if (o_tick || i_dvsr_wr)
                r_q <= '0;
            else
                r_q <= r_q + 32'd1;
            // Period counter wraps naturally at 2^R.
            if (o_tick)
                r_d <= r_d + R'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/chu_pwm_led.sv
// ============================================================================
// Module  : chu_pwm_led
// Purpose : Memory-mapped W-channel PWM slot core for dimming board LEDs.
//           Channels share one prescaler/period counter; each has its own
//           duty register, copied into a shadow register at period wrap so
//           that a duty change never produces a runt pulse.
// Ports   : clk, reset     - clock, synchronous active-high reset
//           cs, read, write- slot select and strobes from the MMIO controller
//           addr           - slot word address
//           wr_data        - write data
//           rd_data        - read data, combinational on addr
//           pwm_out        - registered PWM outputs, one per channel
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module chu_pwm_led
    import chu_pwm_pkg::*;
#(
    parameter int W = 4,
    parameter int R = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] pwm_out
);

    // Register file
    logic [31:0]  r_dvsr;
    logic         r_en;
    logic [R:0]   r_duty   [W];
    logic [R:0]   r_shadow [W];
    logic [W-1:0] r_pwm;

    // Decode and timebase
    logic         w_wr;
    logic         w_dvsr_wr;
    logic         w_ctrl_wr;
    logic [W-1:0] w_duty_wr;
    logic [W-1:0] w_pwm_nxt;
    logic         w_tick;
    logic         w_wrap;
    logic [R-1:0] w_d;
    logic [31:0]  w_rd;

    // Reads have no side effects, so the read strobe is not needed.
    logic w_unused;
    assign w_unused = read;

    assign w_wr      = cs && write;
    assign w_dvsr_wr = w_wr && (addr == PWM_DVSR);
    assign w_ctrl_wr = w_wr && (addr == PWM_CTRL);

    pwm_tick_gen #(
        .R (R)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .i_en      (r_en),
        .i_dvsr    (r_dvsr),
        .i_dvsr_wr (w_dvsr_wr),
        .o_tick    (w_tick),
        .o_wrap    (w_wrap),
        .o_d       (w_d)
    );

    // Per-channel address decode and compare. The shadow is one bit wider
    // than the counter, so any duty >= 2^R is always above the count and the
    // channel saturates at 100%.
    generate
        for (genvar i = 0; i < W; i++) begin : g_chan
            assign w_duty_wr[i] = w_wr && is_duty_addr(addr, i);
            assign w_pwm_nxt[i] = r_en && ({1'b0, w_d} < r_shadow[i]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dvsr <= '0;
            r_en   <= 1'b0;
            r_pwm  <= '0;
            for (int i = 0; i < W; i++) begin
                r_duty[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_dvsr_wr)
                r_dvsr <= wr_data;
            if (w_ctrl_wr)
                r_en <= wr_data[EN_BIT];
            r_pwm <= w_pwm_nxt;
            for (int i = 0; i < W; i++) begin
                if (w_duty_wr[i])
                    r_duty[i] <= wr_data[R:0];
                // Non-blocking read of r_duty: a write landing on the wrap
                // edge is picked up at the following wrap, not this one.
                // While disabled the shadow tracks duty so re-enabling
                // starts with the latest value.
                if (!r_en || w_wrap)
                    r_shadow[i] <= r_duty[i];
            end
        end
    end

    assign pwm_out = r_pwm;

    always_comb begin
        w_rd = '0;
        case (addr)
            PWM_DVSR: w_rd = r_dvsr;
            PWM_CTRL: w_rd[EN_BIT] = r_en;
            PWM_CNT:  w_rd = 32'(w_d);
            default:  w_rd = '0;
        endcase
        for (int i = 0; i < W; i++) begin
            if (is_duty_addr(addr, i))
                w_rd = 32'(r_duty[i]);
        end
    end

    assign rd_data = w_rd;

endmodule

`default_nettype wire

// File: tb/tb_chu_pwm_led.sv
// ============================================================================
// Module  : tb_chu_pwm_led
// Purpose : Self-checking bench for chu_pwm_led (W=4, R=8). A behavioural
//           model tracks the register state and output waveform; directed
//           scenarios measure high time and period, and a randomized phase
//           exercises the register map against the model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_chu_pwm_led;
    import chu_pwm_pkg::*;

    localparam int W      = 4;
    localparam int R      = 8;
    localparam int PERIOD = 1 << R;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs;
    logic         read;
    logic         write;
    logic [4:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic [W-1:0] pwm_out;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;
    int hi [W];

    // Reference model state
    logic [31:0]  m_dvsr;
    logic [31:0]  m_q;
    logic         m_en;
    int           m_d;
    int           m_duty   [W];
    int           m_shadow [W];
    logic [W-1:0] m_pwm;

    chu_pwm_led #(.W(W), .R(R)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of the behavioural model, applying the rules in order:
    // outputs from current state, shadow capture, counters, then writes.
    task automatic model_step();
        bit tick, wrap, dw;
        if (reset) begin
            m_dvsr = 0; m_q = 0; m_en = 0; m_d = 0; m_pwm = '0;
            for (int i = 0; i < W; i++) begin m_duty[i] = 0; m_shadow[i] = 0; end
        end else begin
            tick = m_en && (m_q == m_dvsr);
            wrap = tick && (m_d == PERIOD - 1);
            dw   = cs && write && (addr == PWM_DVSR);
            for (int i = 0; i < W; i++) m_pwm[i] = m_en && (m_d < m_shadow[i]);
            for (int i = 0; i < W; i++) if (!m_en || wrap) m_shadow[i] = m_duty[i];
            if (!m_en) begin
                m_q = 0; m_d = 0;
            end else begin
                m_q = (tick || dw) ? 32'd0 : m_q + 32'd1;
                if (tick) m_d = (m_d + 1) % PERIOD;
            end
            if (cs && write) begin
                if (addr == PWM_DVSR) m_dvsr = wr_data;
                else if (addr == PWM_CTRL) m_en = wr_data[0];
                else if (addr >= 5'h10 && addr < 5'h10 + 5'(W))
                    m_duty[addr - 5'h10] = int'(wr_data[R:0]);
            end
        end
    endtask

    function automatic logic [31:0] mrd(input logic [4:0] a);
        mrd = '0;
        if (a == PWM_DVSR)      mrd = m_dvsr;
        else if (a == PWM_CTRL) mrd = {31'b0, m_en};
        else if (a == PWM_CNT)  mrd = 32'(m_d);
        else if (a >= 5'h10 && a < 5'h10 + 5'(W)) mrd = 32'(m_duty[a - 5'h10]);
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) chk("pwm_model", 32'(pwm_out), 32'(m_pwm));
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; addr = PWM_CNT;
    endtask

    task automatic wait_cnt(input int v);
        addr = PWM_CNT;
        #1;
        for (int k = 0; k < 5000 && rd_data != 32'(v); k++) begin
            @(negedge clk); #1;
        end
        if (rd_data != 32'(v)) chk("wait_cnt", rd_data, 32'(v));
    endtask

    task automatic run_count(input int n);
        for (int i = 0; i < W; i++) hi[i] = 0;
        repeat (n) begin
            for (int i = 0; i < W; i++) hi[i] += int'(pwm_out[i]);
            @(negedge clk); #1;
        end
    endtask

    // Clocks between two rising edges of one channel; -1 when no full period occurs.
    task automatic period_of(input int ch, output int p);
        logic prev;
        int   t0;
        p = -1; t0 = -1; prev = pwm_out[ch];
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk); #1;
            if (pwm_out[ch] && !prev) begin
                if (t0 < 0) t0 = k;
                else begin p = k - t0; break; end
            end
            prev = pwm_out[ch];
        end
    endtask

    initial begin
        int p, k, ha, hb, hc;
        logic [31:0] v0, v1;
        logic [4:0] a;
        logic [4:0] alist [10];

        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_on = 1'b1;

        // Reset values
        addr = PWM_DVSR;            #1; chk("rst_dvsr", rd_data, 0);
        addr = PWM_CTRL;            #1; chk("rst_ctrl", rd_data, 0);
        addr = PWM_CNT;             #1; chk("rst_cnt",  rd_data, 0);
        for (int i = 0; i < W; i++) begin
            addr = PWM_DUTY_BASE + 5'(i); #1; chk("rst_duty", rd_data, 0);
        end
        chk("rst_pwm", 32'(pwm_out), 0);

        // Basic 25% duty on channel 0
        wr(PWM_DUTY_BASE, 64);
        wr(PWM_DVSR, 0);
        wr(PWM_CTRL, 1);
        addr = PWM_CTRL; #1; chk("ctrl_rd", rd_data, 1);
        wait_cnt(1);
        run_count(PERIOD);
        chk("d64_hi0", hi[0], 64);
        chk("d64_hi1", hi[1], 0);
        chk("d64_hi2", hi[2], 0);
        chk("d64_hi3", hi[3], 0);
        period_of(0, p);
        chk("d64_period", p, 256);

        // Saturation and zero duty
        wr(PWM_DUTY_BASE + 5'd1, 256);
        wr(PWM_DUTY_BASE + 5'd2, 300);
        wr(PWM_DUTY_BASE + 5'd3, 0);
        addr = PWM_DUTY_BASE + 5'd2; #1; chk("duty2_rd", rd_data, 300);
        wait_cnt(5); wait_cnt(1);
        run_count(PERIOD);
        chk("sat_hi0", hi[0], 64);
        chk("sat_hi1", hi[1], 256);
        chk("sat_hi2", hi[2], 256);
        chk("zero_hi3", hi[3], 0);

        // Prescaled: DVSR=3 stretches each count to 4 clocks
        wr(PWM_DVSR, 3);
        wr(PWM_DUTY_BASE, 128);
        wait_cnt(5); wait_cnt(1);
        run_count(4 * PERIOD);
        chk("dv3_hi0", hi[0], 512);
        chk("dv3_hi1", hi[1], 1024);
        period_of(0, p);
        chk("dv3_period", p, 1024);

        // DVSR write mid-count restarts the prescaler
        addr = PWM_CNT; #1; v0 = rd_data;
        for (int j = 0; j < 20 && rd_data == v0; j++) begin @(negedge clk); #1; end
        v1 = rd_data;
        @(negedge clk); @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = PWM_DVSR; wr_data = 3;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            cs = 1'b0; write = 1'b0; addr = PWM_CNT; #1;
            if (rd_data != v1) break;
        end
        chk("dvsr_clr", k, 5);

        // Duty change mid-period: old value finishes, new value next period
        wr(PWM_DVSR, 0);
        wr(PWM_DUTY_BASE, 64);
        wait_cnt(5); wait_cnt(1);
        ha = 0; hb = 0;
        for (int j = 0; j < 2 * PERIOD; j++) begin
            if (j < PERIOD) ha += int'(pwm_out[0]); else hb += int'(pwm_out[0]);
            if (j == 99) begin cs = 1'b1; write = 1'b1; addr = PWM_DUTY_BASE; wr_data = 200; end
            @(negedge clk);
            cs = 1'b0; write = 1'b0; addr = PWM_CNT; #1;
        end
        chk("mid_old", ha, 64);
        chk("mid_new", hb, 200);

        // Duty write on the wrap edge: old, old, then new
        wr(PWM_DUTY_BASE, 30);
        wait_cnt(5); wait_cnt(1);
        ha = 0; hb = 0; hc = 0;
        for (int j = 0; j < 3 * PERIOD; j++) begin
            if (j < PERIOD) ha += int'(pwm_out[0]);
            else if (j < 2 * PERIOD) hb += int'(pwm_out[0]);
            else hc += int'(pwm_out[0]);
            if (j == 254) begin cs = 1'b1; write = 1'b1; addr = PWM_DUTY_BASE; wr_data = 150; end
            @(negedge clk);
            cs = 1'b0; write = 1'b0; addr = PWM_CNT; #1;
        end
        chk("wrap_a", ha, 30);
        chk("wrap_b", hb, 30);
        chk("wrap_c", hc, 150);

        // Disable mid-period, then re-enable with a new duty
        wait_cnt(50);
        cs = 1'b1; write = 1'b1; addr = PWM_CTRL; wr_data = 0;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; addr = PWM_CNT;
        @(negedge clk); #1;
        chk("dis_cnt", rd_data, 0);
        chk("dis_pwm", 32'(pwm_out), 0);
        wr(PWM_DUTY_BASE, 77);
        wr(PWM_CTRL, 1);
        #1; chk("reen_cnt", rd_data, 0);
        wait_cnt(1);
        run_count(PERIOD);
        chk("reen_hi0", hi[0], 77);

        // Randomized register traffic against the model
        alist = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h1F};
        for (int it = 0; it < 1500; it++) begin
            @(negedge clk);
            cs = 1'b0; write = 1'b0; read = 1'b0;
            if (it == 700) begin
                reset = 1'b1;
                @(negedge clk); @(negedge clk);
                reset = 1'b0;
                addr = PWM_DVSR; #1; chk("mrst_dvsr", rd_data, 0);
                addr = PWM_CTRL; #1; chk("mrst_ctrl", rd_data, 0);
                addr = PWM_DUTY_BASE; #1; chk("mrst_duty0", rd_data, 0);
                chk("mrst_pwm", 32'(pwm_out), 0);
            end
            a = alist[$urandom_range(0, 9)];
            addr = a;
            cs = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                write = 1'b1;
                wr_data = (a == PWM_DVSR) ? 32'($urandom_range(0, 3)) : $urandom;
            end else begin
                read = 1'b1;
                #1; chk("rnd_rd", rd_data, mrd(a));
            end
        end
        @(negedge clk);
        cs = 1'b0; write = 1'b0; read = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
